// File: rtl/gpio_in_filter_if.sv
// gpio_in_filter_if
// Groups the pad-side inputs, filter configuration and the filtered pin
// levels of the GPIO input filter into a single bundle.
//   pad_in       raw asynchronous pad levels, one bit per pin
//   filt_en      per-bank debounce enable (0 = bypass)
//   filt_len     required stable-tick count minus one
//   prescale     tick divider, one tick every prescale+1 cycles
//   gpio_in_data synchronised and filtered pin levels
// master: the side that drives pads/configuration and reads the result.
// slave:  the filter itself.
interface gpio_in_filter_if #(
  parameter int NUM_BANKS = 8,
  parameter int CNT_W     = 8
);
  localparam int N = 32 * NUM_BANKS;

  logic [N-1:0]         pad_in;
  logic [NUM_BANKS-1:0] filt_en;
  logic [CNT_W-1:0]     filt_len;
  logic [15:0]          prescale;
  logic [N-1:0]         gpio_in_data;

  modport master (
    output pad_in,
    output filt_en,
    output filt_len,
    output prescale,
    input  gpio_in_data
  );

  modport slave (
    input  pad_in,
    input  filt_en,
    input  filt_len,
    input  prescale,
    output gpio_in_data
  );
endinterface

// File: rtl/gpio_in_filter.sv
// gpio_in_filter
// Synchronises every GPIO pad through two flops, then either passes the
// level straight through (bank bypass) or debounces it: a pin only takes a
// new level after it has disagreed with the current output for
// filt_len+1 prescaler ticks in a row.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset, clears all state
//   bus    gpio_in_filter_if.slave: pad_in, filt_en, filt_len, prescale in;
//          gpio_in_data out (registered)
module gpio_in_filter #(
  parameter int NUM_BANKS = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_in_filter_if.slave   bus
);
  localparam int N = 32 * NUM_BANKS;

  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [N-1:0]     data_q;
  logic [CNT_W-1:0] cnt [N];
  logic [15:0]      pcnt;
  logic             tick;

  // >= rather than == so a prescale reduction below the running count
  // produces a tick immediately instead of waiting for a 16-bit wrap.
  assign tick = (pcnt >= bus.prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.pad_in;
      s2 <= s1;
    end
  end

  // Counter only advances while it is strictly below filt_len, so it can
  // never wrap; a filt_len lowered below the current count fires on the
  // next tick because the compare is >=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!bus.filt_en[i / 32]) begin
          data_q[i] <= s2[i];
          cnt[i]    <= '0;
        end else if (s2[i] == data_q[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] >= bus.filt_len) begin
            data_q[i] <= s2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.gpio_in_data = data_q;

endmodule
